// File: rtl/mul_stall_controller_pkg.sv
// Shared types and constants for the E-stage multiply stall controller.
// Optional build macro MUL_EARLY_OUT_EN (zero-operand early completion) is honoured by the top.
package mul_stall_controller_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned LATENCY_MIN  = 1;
  localparam int unsigned LATENCY_MAX  = 15;
  localparam int unsigned CNT_W        = $clog2(LATENCY_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mulState_e;

endpackage

// File: rtl/mul_stall_controller_if.sv
// Handshake bundle between the E stage / hazard unit (master) and the multiply controller (slave).
interface mul_stall_controller_if
  import mul_stall_controller_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);

  logic            mul_req_i;
  logic            op_hi_i;
  logic [XLEN-1:0] src_a_i;
  logic [XLEN-1:0] src_b_i;
  logic [4:0]      rd_e_i;
  logic            flush_e_i;
  logic            mul_stall_o;
  logic [XLEN-1:0] result_o;
  logic            result_valid_o;
  logic [4:0]      rd_o;

  modport master (
    output mul_req_i, op_hi_i, src_a_i, src_b_i, rd_e_i, flush_e_i,
    input  mul_stall_o, result_o, result_valid_o, rd_o
  );

  modport slave (
    input  mul_req_i, op_hi_i, src_a_i, src_b_i, rd_e_i, flush_e_i,
    output mul_stall_o, result_o, result_valid_o, rd_o
  );

endinterface

// File: rtl/mul_stall_controller_mul_pipe.sv
// Free-running signed x signed multiplier with STAGES output registers (STAGES=0 is purely combinational).
// The multiply is written as one expression; synthesis retiming spreads it across the stages.
module mul_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [XLEN-1:0] a,
  input  logic signed [XLEN-1:0] b,
  output logic [2*XLEN-1:0]      product
);

  localparam int unsigned PW = 2 * XLEN;

  logic signed [PW-1:0] aExt;
  logic signed [PW-1:0] bExt;
  logic signed [PW-1:0] full;

  assign aExt = {{XLEN{a[XLEN-1]}}, a};
  assign bExt = {{XLEN{b[XLEN-1]}}, b};
  assign full = aExt * bExt;

  if (STAGES == 0) begin : gComb
    assign product = full;
  end else begin : gPipe
    logic [PW-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(STAGES); i++) stage[i] <= '0;
      end else begin
        stage[0] <= full;
        for (int i = 1; i < int'(STAGES); i++) stage[i] <= stage[i-1];
      end
    end

    assign product = stage[STAGES-1];
  end

endmodule

// File: rtl/mul_stall_controller.sv
// Multi-cycle multiply controller: stalls F/D/E for LATENCY cycles and returns one product half.
// Define MUL_EARLY_OUT_EN to complete zero-operand multiplies in a single stall cycle.
module mul_stall_controller
  import mul_stall_controller_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter int unsigned LATENCY = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  mul_stall_controller_if.slave bus
);

  localparam int unsigned PW = 2 * XLEN;

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : gBadLatency
    $error("mul_stall_controller: LATENCY out of range");
  end

  mulState_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntDec;
  logic             opHiReg;
  logic [4:0]       rdReg;
  logic [XLEN-1:0]  resultReg;
  logic [4:0]       rdOut;
  logic             resultValid;
  logic             accept;
  logic             stall;
  logic [PW-1:0]    product;
  logic [XLEN-1:0]  prodLo;
  logic [XLEN-1:0]  prodHi;

  // Pipe sees the live operands; the capture into resultReg is the final of LATENCY stages.
  mul_pipe #(
    .XLEN   (XLEN),
    .STAGES (LATENCY - 1)
  ) uMulPipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (bus.src_a_i),
    .b       (bus.src_b_i),
    .product (product)
  );

  assign prodLo = product[XLEN-1:0];
  assign prodHi = product[PW-1:XLEN];

`ifdef MUL_EARLY_OUT_EN
  logic zeroOperand;
  assign zeroOperand = (bus.src_a_i == '0) || (bus.src_b_i == '0);
`endif

  // Stall is asserted in the accepting IDLE cycle and in every unflushed BUSY cycle.
  always_comb begin
    accept = 1'b0;
    stall  = 1'b0;
    cntDec = cnt - CNT_W'(1);
    accept = (state == IDLE) && bus.mul_req_i && !bus.flush_e_i;
    stall  = rst_n && (accept || ((state == BUSY) && !bus.flush_e_i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      opHiReg     <= 1'b0;
      rdReg       <= '0;
      resultReg   <= '0;
      rdOut       <= '0;
      resultValid <= 1'b0;
    end else begin
      resultValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            opHiReg <= bus.op_hi_i;
            rdReg   <= bus.rd_e_i;
            cnt     <= CNT_W'(LATENCY - 1);
`ifdef MUL_EARLY_OUT_EN
            if (zeroOperand) begin
              state       <= DONE;
              resultValid <= 1'b1;
              resultReg   <= '0;
              rdOut       <= bus.rd_e_i;
            end else
`endif
            if (LATENCY == 1) begin
              state       <= DONE;
              resultValid <= 1'b1;
              resultReg   <= bus.op_hi_i ? prodHi : prodLo;
              rdOut       <= bus.rd_e_i;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.flush_e_i) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cntDec;
            if (cntDec == '0) begin
              state       <= DONE;
              resultValid <= 1'b1;
              resultReg   <= opHiReg ? prodHi : prodLo;
              rdOut       <= rdReg;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mul_stall_o    = stall;
  assign bus.result_o       = resultReg;
  assign bus.result_valid_o = resultValid;
  assign bus.rd_o           = rdOut;

endmodule

// File: tb/tb_mul_stall_controller.sv
// Directed bench for mul_stall_controller (LATENCY=3) with a result scoreboard.
// Zero-operand expectations follow MUL_EARLY_OUT_EN when the bench is built with it.
module tb_mul_stall_controller;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned LATENCY = 3;
`ifdef MUL_EARLY_OUT_EN
  localparam int ZERO_STALL = 1;
`else
  localparam int ZERO_STALL = int'(LATENCY);
`endif

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } expEntry_t;

  logic      clk;
  logic      rst_n;
  int        tests = 0;
  int        fails = 0;
  int        cyc   = 0;
  expEntry_t sb[$];
  int        pulseCycles[$];
  expEntry_t monExp;

  mul_stall_controller_if #(.XLEN(XLEN)) bus ();

  mul_stall_controller #(
    .XLEN    (XLEN),
    .LATENCY (LATENCY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic hi);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return hi ? p[63:32] : p[31:0];
  endfunction

  task automatic drive(input logic req, input logic [31:0] a, input logic [31:0] b,
                       input logic hi, input logic [4:0] rd);
    bus.mul_req_i = req;
    bus.src_a_i   = a;
    bus.src_b_i   = b;
    bus.op_hi_i   = hi;
    bus.rd_e_i    = rd;
  endtask

  // One multiply: accept on the next edge, count stall cycles, drop the request in DONE.
  task automatic mulOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic hi, input logic [4:0] rd, input logic [31:0] expRes,
                       input int expStall, input bit flushAtDone);
    int n;
    expEntry_t e;
    @(posedge clk); #1;
    bus.flush_e_i = 1'b0;
    drive(1'b1, a, b, hi, rd);
    e.res = expRes;
    e.rd  = rd;
    sb.push_back(e);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!bus.mul_stall_o) break;
      n++;
      @(posedge clk); #1;
    end
    bus.mul_req_i = 1'b0;
    check($sformatf("%s_stall_cycles", tag), 64'(n), 64'(expStall));
    if (flushAtDone) begin
      bus.flush_e_i = 1'b1;
      @(negedge clk); #1;
      bus.flush_e_i = 1'b0;
    end
  endtask

  // Scoreboard: every result_valid_o pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && bus.result_valid_o) begin
      pulseCycles.push_back(cyc);
      check("valid_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        monExp = sb.pop_front();
        check("result", 64'(bus.result_o), 64'(monExp.res));
        check("rd", 64'(bus.rd_o), 64'(monExp.rd));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          base;
    expEntry_t   e;

    rst_n = 1'b1;
    bus.flush_e_i = 1'b0;
    drive(1'b1, 32'd7, 32'd9, 1'b0, 5'd3);
    #2 rst_n = 1'b0;

    // Reset holds everything low even with a request pending.
    repeat (2) @(posedge clk);
    #2;
    check("reset_stall", 64'(bus.mul_stall_o), 64'(0));
    check("reset_valid", 64'(bus.result_valid_o), 64'(0));
    check("reset_result", 64'(bus.result_o), 64'(0));
    check("reset_rd", 64'(bus.rd_o), 64'(0));
    bus.mul_req_i = 1'b0;
    rst_n = 1'b1;

    mulOp("neg_lo", 32'd7, 32'hFFFF_FFFD, 1'b0, 5'd5, 32'hFFFF_FFEB, 3, 1'b0);
    mulOp("min_hi", 32'h8000_0000, 32'h8000_0000, 1'b1, 5'd12, 32'h4000_0000, 3, 1'b1);

    // Outputs hold between DONE pulses.
    repeat (2) @(posedge clk);
    #2;
    check("hold_result", 64'(bus.result_o), 64'h4000_0000);
    check("hold_rd", 64'(bus.rd_o), 64'(12));
    check("hold_valid", 64'(bus.result_valid_o), 64'(0));

    mulOp("mixed_hi", 32'hFFFE_1DC0, 32'd98765, 1'b1, 5'd31,
          model(32'hFFFE_1DC0, 32'd98765, 1'b1), 3, 1'b0);
    mulOp("max_hi", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 5'd1, 32'h3FFF_FFFF, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      mulOp("rand", ra, rb, i[0], 5'($urandom_range(0, 31)), model(ra, rb, i[0]), 3, 1'b0);
    end

    // Flush in the second BUSY cycle.
    @(posedge clk); #1;
    drive(1'b1, 32'd3, 32'd4, 1'b0, 5'd6);
    @(posedge clk); #2;
    check("flush_busy1_stall", 64'(bus.mul_stall_o), 64'(1));
    @(posedge clk); #1;
    bus.flush_e_i = 1'b1;
    #1;
    check("flush_stall_drop", 64'(bus.mul_stall_o), 64'(0));
    @(posedge clk); #1;
    bus.flush_e_i = 1'b0;
    bus.mul_req_i = 1'b0;
    #1;
    check("flush_idle_stall", 64'(bus.mul_stall_o), 64'(0));
    check("flush_no_valid", 64'(bus.result_valid_o), 64'(0));
    mulOp("after_flush", 32'd100, 32'd200, 1'b0, 5'd8, 32'd20000, 3, 1'b0);

    // Flush in IDLE blocks acceptance.
    @(posedge clk); #1;
    drive(1'b1, 32'd5, 32'd5, 1'b0, 5'd2);
    bus.flush_e_i = 1'b1;
    #1;
    check("idle_flush_stall", 64'(bus.mul_stall_o), 64'(0));
    @(posedge clk); #1;
    bus.flush_e_i = 1'b0;
    bus.mul_req_i = 1'b0;
    #1;
    check("idle_flush_not_accepted", 64'(bus.mul_stall_o), 64'(0));

    // Back-to-back with mul_req_i held high: pulses LATENCY+1 cycles apart.
    base = pulseCycles.size();
    @(posedge clk); #1;
    drive(1'b1, 32'hFFFF_FFFB, 32'd6, 1'b1, 5'd9);
    e.res = 32'hFFFF_FFFF;
    e.rd  = 5'd9;
    sb.push_back(e);
    sb.push_back(e);
    repeat (3) @(posedge clk);
    #2;
    check("b2b_done_no_stall", 64'(bus.mul_stall_o), 64'(0));
    @(posedge clk); #2;
    check("b2b_reaccept_stall", 64'(bus.mul_stall_o), 64'(1));
    @(posedge clk); #1;
    bus.mul_req_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pulseCycles.size() >= base + 2) break;
      @(posedge clk);
    end
    #1;
    check("b2b_pulse_count", 64'(pulseCycles.size() - base), 64'(2));
    if (pulseCycles.size() >= base + 2)
      check("b2b_pulse_gap", 64'(pulseCycles[base+1] - pulseCycles[base]), 64'(LATENCY + 1));

    // Reset mid-BUSY discards the operation.
    @(posedge clk); #1;
    drive(1'b1, 32'd11, 32'd13, 1'b0, 5'd14);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy_stall", 64'(bus.mul_stall_o), 64'(0));
    check("rst_busy_valid", 64'(bus.result_valid_o), 64'(0));
    check("rst_busy_result", 64'(bus.result_o), 64'(0));
    check("rst_busy_rd", 64'(bus.rd_o), 64'(0));
    @(posedge clk); #1;
    bus.mul_req_i = 1'b0;
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);

    mulOp("post_reset", 32'd21, 32'd2, 1'b0, 5'd4, 32'd42, 3, 1'b0);
    mulOp("zero_b", 32'h0000_1234, 32'd0, 1'b0, 5'd7, 32'd0, ZERO_STALL, 1'b0);
    mulOp("zero_a_hi", 32'd0, 32'hFFFF_FFFF, 1'b1, 5'd10, 32'd0, ZERO_STALL, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
